// File: rtl/player_ctrl.sv
// Player state machine for a shoot-em-up: movement with clamping, hit handling,
// death freeze, invulnerable respawn window and game-over, all on the game tick.
module player_ctrl #(
  parameter int W          = 10,
  parameter int XMIN       = 24,
  parameter int XMAX       = 430,
  parameter int YMIN       = 25,
  parameter int YMAX       = 465,
  parameter int XSPAWN     = 220,
  parameter int YSPAWN     = 360,
  parameter int SPD        = 7,
  parameter int SPD_FOCUS  = 3,
  parameter int DEAD_TICKS = 30,
  parameter int INV_TICKS  = 60,
  parameter int LIVES      = 3
) (
  input  logic         clk22,
  input  logic         rst,
  input  logic         gamestart,
  input  logic [3:0]   btnstate,
  input  logic         focus,
  input  logic         hit,
  output logic [W-1:0] posx,
  output logic [W-1:0] posy,
  output logic [2:0]   lives,
  output logic         alive,
  output logic         invuln,
  output logic         blink,
  output logic         gameover
);

  localparam int CMAX = (DEAD_TICKS > INV_TICKS) ? DEAD_TICKS : INV_TICKS;
  localparam int CW   = ($clog2(CMAX) < 3) ? 3 : $clog2(CMAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    DEAD = 3'd2,
    INV  = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t        state_q;
  logic [W-1:0]  posx_q, posy_q, posx_d, posy_d, step;
  logic [2:0]    lives_q;
  logic [CW-1:0] cnt_q;

  // Comparisons are done one bit wider so no W-bit position can wrap.
  function automatic logic [W-1:0] axis_next(input logic [W-1:0] p,
                                             input logic dec, input logic inc,
                                             input logic [W-1:0] s,
                                             input logic [W-1:0] lo,
                                             input logic [W-1:0] hi);
    logic [W:0] pw, sw;
    pw = {1'b0, p};
    sw = {1'b0, s};
    if (dec && !inc) begin
      if (pw <= ({1'b0, lo} + sw)) axis_next = lo;
      else                         axis_next = p - s;
    end else if (inc && !dec) begin
      if ((pw + sw) >= {1'b0, hi}) axis_next = hi;
      else                         axis_next = p + s;
    end else begin
      axis_next = p;
    end
  endfunction

  always_comb begin
    step   = focus ? W'(SPD_FOCUS) : W'(SPD);
    posy_d = axis_next(posy_q, btnstate[3], btnstate[2], step, W'(YMIN), W'(YMAX));
    posx_d = axis_next(posx_q, btnstate[1], btnstate[0], step, W'(XMIN), W'(XMAX));
  end

  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      posx_q  <= W'(XSPAWN);
      posy_q  <= W'(YSPAWN);
      lives_q <= 3'(LIVES);
      cnt_q   <= '0;
    end else if (gamestart) begin
      state_q <= PLAY;
      posx_q  <= W'(XSPAWN);
      posy_q  <= W'(YSPAWN);
      lives_q <= 3'(LIVES);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, OVER: begin
          state_q <= state_q;
        end
        PLAY: begin
          if (hit) begin
            lives_q <= lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_q <= OVER;
            end else begin
              state_q <= DEAD;
              cnt_q   <= CW'(DEAD_TICKS - 1);
            end
          end else begin
            posx_q <= posx_d;
            posy_q <= posy_d;
          end
        end
        DEAD: begin
          if (cnt_q == '0) begin
            state_q <= INV;
            posx_q  <= W'(XSPAWN);
            posy_q  <= W'(YSPAWN);
            cnt_q   <= CW'(INV_TICKS - 1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        INV: begin
          posx_q <= posx_d;
          posy_q <= posy_d;
          if (cnt_q == '0) state_q <= PLAY;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign posx     = posx_q;
  assign posy     = posy_q;
  assign lives    = lives_q;
  assign alive    = (state_q == PLAY) || (state_q == INV);
  assign invuln   = (state_q == INV);
  assign gameover = (state_q == OVER);
  assign blink    = invuln & cnt_q[2];

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed scenarios plus a long randomized
// run compared against a tick-level behavioural model of the player rules.
module tb_player_ctrl;
  localparam int W = 10, XMIN = 24, XMAX = 430, YMIN = 25, YMAX = 465;
  localparam int XSPAWN = 220, YSPAWN = 360, SPD = 7, SPD_FOCUS = 3;
  localparam int DEAD_TICKS = 30, INV_TICKS = 60, LIVES = 3;
  localparam int M_IDLE = 0, M_PLAY = 1, M_DEAD = 2, M_INV = 3, M_OVER = 4;
  localparam int VW = 2 * W + 7;

  logic         clk22 = 1'b0;
  logic         rst, gamestart, focus, hit;
  logic [3:0]   btnstate;
  logic [W-1:0] posx, posy;
  logic [2:0]   lives;
  logic         alive, invuln, blink, gameover;

  int tests = 0;
  int fails = 0;

  int m_st, m_x, m_y, m_lives, m_rem;

  player_ctrl #(.W(W), .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX),
                .XSPAWN(XSPAWN), .YSPAWN(YSPAWN), .SPD(SPD), .SPD_FOCUS(SPD_FOCUS),
                .DEAD_TICKS(DEAD_TICKS), .INV_TICKS(INV_TICKS), .LIVES(LIVES)) dut (
    .clk22(clk22), .rst(rst), .gamestart(gamestart), .btnstate(btnstate),
    .focus(focus), .hit(hit), .posx(posx), .posy(posy), .lives(lives),
    .alive(alive), .invuln(invuln), .blink(blink), .gameover(gameover)
  );

  always #5 clk22 = ~clk22;

  task automatic tick();
    @(posedge clk22);
    #1;
  endtask

  function automatic int mv(int p, bit neg, bit pos, int s, int lo, int hi);
    if (neg && !pos) return (p <= lo + s) ? lo : p - s;
    if (pos && !neg) return (p + s >= hi) ? hi : p + s;
    return p;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_x = XSPAWN; m_y = YSPAWN; m_lives = LIVES; m_rem = 0;
  endtask

  task automatic model_move(input logic [3:0] b, input bit f);
    int s;
    s = f ? SPD_FOCUS : SPD;
    m_y = mv(m_y, b[3], b[2], s, YMIN, YMAX);
    m_x = mv(m_x, b[1], b[0], s, XMIN, XMAX);
  endtask

  // m_rem counts the ticks still to spend in DEAD or INV.
  task automatic model_tick(input bit gs, input logic [3:0] b, input bit f, input bit h);
    if (gs) begin
      m_st = M_PLAY; m_x = XSPAWN; m_y = YSPAWN; m_lives = LIVES; m_rem = 0;
    end else if (m_st == M_PLAY) begin
      if (h) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_st = M_OVER;
        else begin m_st = M_DEAD; m_rem = DEAD_TICKS; end
      end else model_move(b, f);
    end else if (m_st == M_DEAD) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_st = M_INV; m_x = XSPAWN; m_y = YSPAWN; m_rem = INV_TICKS;
      end
    end else if (m_st == M_INV) begin
      model_move(b, f);
      m_rem = m_rem - 1;
      if (m_rem == 0) m_st = M_PLAY;
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    bit bl;
    bl = (m_st == M_INV) && ((((m_rem - 1) >> 2) & 1) == 1);
    return {W'(m_x), W'(m_y), 3'(m_lives), m_st == M_PLAY || m_st == M_INV,
            m_st == M_INV, bl, m_st == M_OVER};
  endfunction

  task automatic clear_inputs();
    gamestart = 1'b0; focus = 1'b0; hit = 1'b0; btnstate = 4'b0000;
  endtask

  task automatic test_reset();
    logic [VW-1:0] exp_v;
    rst = 1'b1;
    clear_inputs();
    #12;
    exp_v = {W'(XSPAWN), W'(YSPAWN), 3'd3, 4'b0000};
    tests++;
    if ({posx, posy, lives, alive, invuln, blink, gameover} !== exp_v) begin
      $display("FAIL reset_state: got %h want %h",
               {posx, posy, lives, alive, invuln, blink, gameover}, exp_v);
      fails++;
    end
    @(negedge clk22);
    rst = 1'b0;
    btnstate = 4'b1000; hit = 1'b1;
    tick();
    tests++;
    if (alive !== 1'b0 || posy !== W'(YSPAWN) || lives !== 3'd3) begin
      $display("FAIL idle_hold: alive %b posy %0d lives %0d want 0 %0d 3", alive, posy, lives, YSPAWN);
      fails++;
    end
    clear_inputs();
  endtask

  task automatic test_move_up();
    int exp_y[3] = '{353, 346, 339};
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    tests++;
    if (posy !== W'(360) || posx !== W'(220) || alive !== 1'b1) begin
      $display("FAIL start_pos: got (%0d,%0d) alive %b want (220,360) 1", posx, posy, alive);
      fails++;
    end
    btnstate = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (posy !== W'(exp_y[i]) || posx !== W'(220)) begin
        $display("FAIL move_up_%0d: got (%0d,%0d) want (220,%0d)", i, posx, posy, exp_y[i]);
        fails++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_clamp();
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    btnstate = 4'b1000;
    repeat (45) tick();
    focus = 1'b1;
    repeat (5) tick();
    tests++;
    if (posy !== W'(30)) begin
      $display("FAIL clamp_setup: got posy %0d want 30", posy);
      fails++;
    end
    focus = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (posy !== W'(YMIN)) begin
        $display("FAIL clamp_top_%0d: got posy %0d want %0d", i, posy, YMIN);
        fails++;
      end
    end
    btnstate = 4'b1100;
    tick();
    tests++;
    if (posy !== W'(YMIN) || posx !== W'(220)) begin
      $display("FAIL opposite_btns: got (%0d,%0d) want (220,%0d)", posx, posy, YMIN);
      fails++;
    end
    btnstate = 4'b0001; focus = 1'b1;
    tick();
    tests++;
    if (posx !== W'(223)) begin
      $display("FAIL focus_right: got posx %0d want 223", posx);
      fails++;
    end
    clear_inputs();
  endtask

  task automatic test_hit_respawn();
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    btnstate = 4'b1000;
    repeat (2) tick();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tests++;
    if (lives !== 3'd2 || alive !== 1'b0 || posy !== W'(346)) begin
      $display("FAIL hit_dead: lives %0d alive %b posy %0d want 2 0 346", lives, alive, posy);
      fails++;
    end
    repeat (29) tick();
    tests++;
    if (alive !== 1'b0 || posy !== W'(346)) begin
      $display("FAIL dead_frozen: alive %b posy %0d want 0 346", alive, posy);
      fails++;
    end
    btnstate = 4'b0000;
    tick();
    tests++;
    if (posx !== W'(220) || posy !== W'(360) || invuln !== 1'b1 || alive !== 1'b1) begin
      $display("FAIL respawn: got (%0d,%0d) inv %b alive %b want (220,360) 1 1", posx, posy, invuln, alive);
      fails++;
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tests++;
    if (lives !== 3'd2 || invuln !== 1'b1) begin
      $display("FAIL inv_hit_ignored: lives %0d inv %b want 2 1", lives, invuln);
      fails++;
    end
    repeat (3) tick();
    tests++;
    if (blink !== 1'b1) begin
      $display("FAIL blink_on: got %b want 1", blink);
      fails++;
    end
    repeat (55) tick();
    tests++;
    if (invuln !== 1'b1) begin
      $display("FAIL inv_last_tick: got %b want 1", invuln);
      fails++;
    end
    tick();
    tests++;
    if (invuln !== 1'b0 || alive !== 1'b1 || blink !== 1'b0) begin
      $display("FAIL inv_end: inv %b alive %b blink %b want 0 1 0", invuln, alive, blink);
      fails++;
    end
    clear_inputs();
  endtask

  task automatic test_gameover();
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1;
      tick();
      hit = 1'b0;
      if (i < 2) repeat (DEAD_TICKS + INV_TICKS) tick();
    end
    tests++;
    if (gameover !== 1'b1 || lives !== 3'd0 || alive !== 1'b0) begin
      $display("FAIL gameover: go %b lives %0d alive %b want 1 0 0", gameover, lives, alive);
      fails++;
    end
    btnstate = 4'b1000;
    repeat (3) tick();
    tests++;
    if (posy !== W'(360) || gameover !== 1'b1) begin
      $display("FAIL over_frozen: posy %0d go %b want 360 1", posy, gameover);
      fails++;
    end
    btnstate = 4'b0000; gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    tests++;
    if (alive !== 1'b1 || lives !== 3'd3 || gameover !== 1'b0) begin
      $display("FAIL restart: alive %b lives %0d go %b want 1 3 0", alive, lives, gameover);
      fails++;
    end
    clear_inputs();
  endtask

  task automatic test_start_beats_hit();
    btnstate = 4'b1000;
    repeat (2) tick();
    btnstate = 4'b0000; gamestart = 1'b1; hit = 1'b1;
    tick();
    tests++;
    if (lives !== 3'd3 || alive !== 1'b1 || invuln !== 1'b0 || posy !== W'(360) || posx !== W'(220)) begin
      $display("FAIL start_beats_hit: lives %0d alive %b inv %b pos (%0d,%0d) want 3 1 0 (220,360)",
               lives, alive, invuln, posx, posy);
      fails++;
    end
    clear_inputs();
  endtask

  task automatic test_rst_mid_dead();
    logic [VW-1:0] exp_v;
    exp_v = {W'(XSPAWN), W'(YSPAWN), 3'd3, 4'b0000};
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0; btnstate = 4'b0010;
    tick();
    btnstate = 4'b0000; hit = 1'b1;
    tick();
    hit = 1'b0;
    repeat (17) tick();
    tests++;
    if (alive !== 1'b0 || lives !== 3'd2 || posx !== W'(213)) begin
      $display("FAIL pre_rst_dead: alive %b lives %0d posx %0d want 0 2 213", alive, lives, posx);
      fails++;
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({posx, posy, lives, alive, invuln, blink, gameover} !== exp_v) begin
      $display("FAIL rst_mid_dead: got %h want %h", {posx, posy, lives, alive, invuln, blink, gameover}, exp_v);
      fails++;
    end
    #1 rst = 1'b0;
    btnstate = 4'b1000; hit = 1'b1;
    repeat (3) tick();
    tests++;
    if ({posx, posy, lives, alive, invuln, blink, gameover} !== exp_v) begin
      $display("FAIL idle_after_rst: got %h want %h", {posx, posy, lives, alive, invuln, blink, gameover}, exp_v);
      fails++;
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [3:0] b = 4'b0000;
    int run = 0;
    int bad = 0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        tick();
        model_tick(gamestart, btnstate, focus, hit);
      end else begin
        if (run == 0) begin
          b = 4'($urandom);
          run = $urandom_range(1, 40);
        end
        run--;
        gamestart = ($urandom_range(0, 59) == 0) ||
                    ((m_st == M_OVER || m_st == M_IDLE) && $urandom_range(0, 7) == 0);
        hit = ($urandom_range(0, 11) == 0);
        focus = 1'($urandom_range(0, 1));
        btnstate = b;
        tick();
        model_tick(gamestart, btnstate, focus, hit);
      end
      tests++;
      if ({posx, posy, lives, alive, invuln, blink, gameover} !== model_vec()) begin
        fails++;
        if (bad < 10)
          $display("FAIL random_tick_%0d: got %h want %h", i,
                   {posx, posy, lives, alive, invuln, blink, gameover}, model_vec());
        bad++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_move_up();
    test_clamp();
    test_hit_respawn();
    test_gameover();
    test_start_beats_hit();
    test_rst_mid_dead();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
